// File: rtl/adc_seq_ltc2308_if.sv
// Bus bundle between the LTC2308 frame engine and its surroundings: scan control in,
// ADC pins, and channel-tagged sample output.
interface adc_seq_ltc2308_if #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned DATA_W = 12
);
  logic              enable;
  logic [NUM_CH-1:0] ch_mask;
  logic [NUM_CH-1:0] diff_mask;
  logic [NUM_CH-1:0] uni_mask;
  logic              ADC_CONVST;
  logic              ADC_SCK;
  logic              ADC_SDI;
  logic              ADC_SDO;
  logic [DATA_W-1:0] data_out;
  logic [2:0]        data_ch;
  logic              data_valid;
  logic              busy;

  // Sequencer side
  modport master (
    input  enable, ch_mask, diff_mask, uni_mask, ADC_SDO,
    output ADC_CONVST, ADC_SCK, ADC_SDI, data_out, data_ch, data_valid, busy
  );

  // Controller / ADC side
  modport slave (
    output enable, ch_mask, diff_mask, uni_mask, ADC_SDO,
    input  ADC_CONVST, ADC_SCK, ADC_SDI, data_out, data_ch, data_valid, busy
  );
endinterface

// File: rtl/adc_seq_ltc2308.sv
// LTC2308-style frame engine: CONVST pulse, conversion wait, then DATA_W SCK periods that
// shift the 6-bit config word out on SDI and the previous conversion in from SDO.
module adc_seq_ltc2308 #(
  parameter int unsigned NUM_CH   = 8,
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned SCK_HALF = 2,
  parameter int unsigned T_CONVST = 3,
  parameter int unsigned T_CONV   = 80,
  parameter logic        SLP      = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  adc_seq_ltc2308_if.master bus
);

  localparam int unsigned CNT_MAX = (T_CONV > T_CONVST) ?
                                    ((T_CONV > SCK_HALF) ? T_CONV : SCK_HALF) :
                                    ((T_CONVST > SCK_HALF) ? T_CONVST : SCK_HALF);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {StIdle, StConvHi, StConvWait, StShift} state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [BIT_W-1:0]  bit_q;
  logic [DATA_W-1:0] shreg_q;
  logic [2:0]        ch_cur_q;   // channel configured in the current frame
  logic [2:0]        ch_prev_q;  // channel whose conversion is being read back
  logic              prime_q;
  logic              convst_q;
  logic              sck_q;
  logic              sdi_q;
  logic [DATA_W-1:0] data_q;
  logic [2:0]        data_ch_q;
  logic              valid_q;
  logic              busy_q;

  logic              mask_any;
  logic [2:0]        ch_next;
  logic              found;
  int unsigned       rr_idx;
  logic [DATA_W-1:0] cfg_word;
  logic [BIT_W-1:0]  bit_nxt;

  assign bus.ADC_CONVST = convst_q;
  assign bus.ADC_SCK    = sck_q;
  assign bus.ADC_SDI    = sdi_q;
  assign bus.data_out   = data_q;
  assign bus.data_ch    = data_ch_q;
  assign bus.data_valid = valid_q;
  assign bus.busy       = busy_q;

  // Round-robin pick: first enabled channel strictly after ch_cur_q, ascending with wrap.
  always_comb begin
    mask_any = |bus.ch_mask;
    ch_next  = ch_cur_q;
    found    = 1'b0;
    rr_idx   = 0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      rr_idx = {29'd0, ch_cur_q} + i;
      if (rr_idx >= NUM_CH) rr_idx = rr_idx - NUM_CH;
      if (!found && bus.ch_mask[rr_idx[2:0]]) begin
        found   = 1'b1;
        ch_next = rr_idx[2:0];
      end
    end
  end

  // Config word for the current channel; bit 0 (S/D) goes out first, tail bits are zero.
  always_comb begin
    cfg_word      = '0;
    cfg_word[5:0] = {SLP, bus.uni_mask[ch_cur_q], ch_cur_q[1], ch_cur_q[2], ch_cur_q[0],
                     ~bus.diff_mask[ch_cur_q]};
    bit_nxt       = bit_q + BIT_W'(1);
  end

  // Frame FSM with all pin and sample outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      ch_cur_q  <= 3'(NUM_CH - 1);
      ch_prev_q <= '0;
      prime_q   <= 1'b0;
      convst_q  <= 1'b0;
      sck_q     <= 1'b0;
      sdi_q     <= 1'b0;
      data_q    <= '0;
      data_ch_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          prime_q <= 1'b0;
          if (bus.enable && mask_any) begin
            state_q  <= StConvHi;
            ch_cur_q <= ch_next;
            convst_q <= 1'b1;
            busy_q   <= 1'b1;
            cnt_q    <= CNT_W'(T_CONVST - 1);
          end
        end
        StConvHi: begin
          if (cnt_q == '0) begin
            convst_q <= 1'b0;
            state_q  <= StConvWait;
            cnt_q    <= CNT_W'(T_CONV - 1);
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        StConvWait: begin
          if (cnt_q == '0) begin
            state_q <= StShift;
            sck_q   <= 1'b0;
            sdi_q   <= cfg_word[0];
            bit_q   <= '0;
            cnt_q   <= CNT_W'(SCK_HALF - 1);
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        StShift: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else if (!sck_q) begin
            sck_q   <= 1'b1;
            shreg_q <= {shreg_q[DATA_W-2:0], bus.ADC_SDO};
            cnt_q   <= CNT_W'(SCK_HALF - 1);
          end else if (bit_q == BIT_W'(DATA_W - 1)) begin
            sck_q     <= 1'b0;
            sdi_q     <= 1'b0;
            ch_prev_q <= ch_cur_q;
            // The word just read belongs to the previous frame's configuration.
            if (prime_q) begin
              valid_q   <= 1'b1;
              data_q    <= shreg_q;
              data_ch_q <= ch_prev_q;
            end
            if (bus.enable && mask_any) begin
              state_q  <= StConvHi;
              ch_cur_q <= ch_next;
              convst_q <= 1'b1;
              cnt_q    <= CNT_W'(T_CONVST - 1);
              prime_q  <= 1'b1;
            end else begin
              // In-flight conversion is dropped; scanning restarts from channel 0.
              state_q  <= StIdle;
              busy_q   <= 1'b0;
              prime_q  <= 1'b0;
              ch_cur_q <= 3'(NUM_CH - 1);
            end
          end else begin
            sck_q <= 1'b0;
            bit_q <= bit_nxt;
            sdi_q <= cfg_word[bit_nxt];
            cnt_q <= CNT_W'(SCK_HALF - 1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
